// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;

  function automatic int div_iter(input int xlen, input int bits_per_cycle);
    return xlen / bits_per_cycle;
  endfunction

  function automatic int div_cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // One extra guard bit above the partial remainder makes the borrow explicit.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {2'b00, divisor};
    if (diff[XLEN+1]) begin
      rem_out = shifted[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divider for RV32M DIV/DIVU/REM/REMU,
// with RISC-V divide-by-zero and signed-overflow results.
module iter_div
  import div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int ITER = div_iter(XLEN, BITS_PER_CYCLE);
  localparam int CW   = div_cnt_width(ITER);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_next;

  logic [XLEN:0]   rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r;

  logic            dvd_neg, dvs_neg, div_zero, overflow;
  logic [XLEN-1:0] dvd_abs, dvs_abs;

  logic [XLEN:0]   rem_chain [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain [BITS_PER_CYCLE+1];

  // The magnitude of the most negative value is simply its unsigned bit pattern.
  always_comb begin
    dvd_neg  = is_signed & dividend[XLEN-1];
    dvs_neg  = is_signed & divisor[XLEN-1];
    dvd_abs  = dvd_neg ? -dividend : dividend;
    dvs_abs  = dvs_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);
  end

  assign rem_chain[0] = rem_r;
  assign quo_chain[0] = quo_r;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[g]),
      .quo_in  (quo_chain[g]),
      .divisor (dvs_r),
      .rem_out (rem_chain[g+1]),
      .quo_out (quo_chain[g+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (div_zero || overflow) ? FIX : CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Special cases are preloaded so FIX passes them through without correction.
  always_ff @(posedge clock) begin
    if (reset) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs_r <= dvs_abs;
            cnt   <= CNT_LAST;
            if (div_zero) begin
              quo_r <= '1;
              rem_r <= {1'b0, dividend};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (overflow) begin
              quo_r <= dividend;
              rem_r <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo_r <= dvd_abs;
              rem_r <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
            end
          end
        end
        CALC: begin
          rem_r <= rem_chain[BITS_PER_CYCLE];
          quo_r <= quo_chain[BITS_PER_CYCLE];
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient  <= neg_q ? -quo_r : quo_r;
          remainder <= neg_r ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
